// File: rtl/core_types_pkg.sv
// Shared core type definitions: physical-register geometry and the PRF read
// request type used between the issue queues and the PRF read arbiter.
package core_types_pkg;

  // Physical register file geometry
  localparam int LOG_PR_COUNT       = 7;
  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = 2;

  // Width of the bank-local register index sent to a bank
  localparam int UPPER_PR_WIDTH = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  // One PR read request as seen by a bank arbiter
  typedef struct packed {
    logic                    valid;
    logic [LOG_PR_COUNT-1:0] PR;
  } prf_rd_req_t;

  // Bank that holds a given PR (low-order interleave)
  function automatic logic [LOG_PRF_BANK_COUNT-1:0] pr_bank(input logic [LOG_PR_COUNT-1:0] pr);
    return pr[LOG_PRF_BANK_COUNT-1:0];
  endfunction

  // Row within the bank for a given PR
  function automatic logic [UPPER_PR_WIDTH-1:0] pr_upper(input logic [LOG_PR_COUNT-1:0] pr);
    return pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
  endfunction

endpackage

// File: rtl/rr_pick_one.sv
// Round-robin single-winner picker: returns the first set request bit found
// scanning upward from ptr_i with wrap, as a one-hot grant plus its index.
module rr_pick_one #(
  parameter int WIDTH     = 4,
  parameter int LOG_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     req_i,
  input  logic [LOG_WIDTH-1:0] ptr_i,
  output logic [WIDTH-1:0]     gnt_o,
  output logic [LOG_WIDTH-1:0] idx_o,
  output logic                 any_o
);

  // Scan requesters in rotated order and keep the first hit
  always_comb begin : pick
    int                   pos;
    logic [LOG_WIDTH-1:0] sel;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    sel   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= WIDTH) begin
        pos = pos - WIDTH;
      end
      sel = LOG_WIDTH'(pos);
      if (!any_o && req_i[sel]) begin
        any_o      = 1'b1;
        gnt_o[sel] = 1'b1;
        idx_o      = sel;
      end
    end
  end

endmodule

// File: rtl/prf_read_arbiter.sv
// PRF read arbiter: shares the banked PRF read ports among the issue queues.
// Each requester has a one-entry pending buffer; each bank runs its own
// round-robin pick; grants are registered into the bank-side read request.
module prf_read_arbiter
  import core_types_pkg::*;
#(
  parameter int REQUESTER_COUNT     = 4,
  parameter int LOG_REQUESTER_COUNT = $clog2(REQUESTER_COUNT)
) (
  input  logic                                               CLK,
  input  logic                                               RST,
  input  logic [REQUESTER_COUNT-1:0]                         req_valid_by_rq,
  input  logic [REQUESTER_COUNT-1:0][LOG_PR_COUNT-1:0]       req_PR_by_rq,
  output logic [REQUESTER_COUNT-1:0]                         req_ready_by_rq,
  input  logic [PRF_BANK_COUNT-1:0]                          bank_ready_by_bank,
  input  logic                                               flush,
  output logic [PRF_BANK_COUNT-1:0]                          bank_read_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][UPPER_PR_WIDTH-1:0]      bank_read_upper_PR_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_REQUESTER_COUNT-1:0] bank_read_rq_by_bank
);

  // Pending buffers, one per requester
  logic [REQUESTER_COUNT-1:0]                   buf_valid_q, buf_valid_d;
  logic [REQUESTER_COUNT-1:0][LOG_PR_COUNT-1:0] buf_pr_q, buf_pr_d;

  // Round-robin pointer per bank
  logic [PRF_BANK_COUNT-1:0][LOG_REQUESTER_COUNT-1:0] rr_ptr_q, rr_ptr_d;

  // Registered bank-side read requests
  logic [PRF_BANK_COUNT-1:0]                          rd_valid_q, rd_valid_d;
  logic [PRF_BANK_COUNT-1:0][UPPER_PR_WIDTH-1:0]      rd_upper_q, rd_upper_d;
  logic [PRF_BANK_COUNT-1:0][LOG_REQUESTER_COUNT-1:0] rd_rq_q, rd_rq_d;

  // Per-cycle arbitration signals
  prf_rd_req_t [REQUESTER_COUNT-1:0]                  cand;
  logic [REQUESTER_COUNT-1:0]                         cand_granted;
  logic [PRF_BANK_COUNT-1:0][REQUESTER_COUNT-1:0]     bank_req;
  logic [PRF_BANK_COUNT-1:0][REQUESTER_COUNT-1:0]     bank_gnt;
  logic [PRF_BANK_COUNT-1:0][LOG_REQUESTER_COUNT-1:0] bank_idx;
  logic [PRF_BANK_COUNT-1:0]                          bank_any;

  // Ready depends only on buffer state, never on this cycle's req_valid
  assign req_ready_by_rq = ~buf_valid_q;

  assign bank_read_valid_by_bank    = rd_valid_q;
  assign bank_read_upper_PR_by_bank = rd_upper_q;
  assign bank_read_rq_by_bank       = rd_rq_q;

  // Candidate per requester: buffered entry wins over the (ignored) incoming req
  always_comb begin
    cand = '0;
    for (int r = 0; r < REQUESTER_COUNT; r++) begin
      cand[r].valid = buf_valid_q[r] | req_valid_by_rq[r];
      cand[r].PR    = buf_valid_q[r] ? buf_pr_q[r] : req_PR_by_rq[r];
    end
  end

  // Route each candidate to the request vector of its target bank
  always_comb begin
    bank_req = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int r = 0; r < REQUESTER_COUNT; r++) begin
        bank_req[b][r] = cand[r].valid
                       && (pr_bank(cand[r].PR) == LOG_PRF_BANK_COUNT'(b))
                       && bank_ready_by_bank[b]
                       && !flush;
      end
    end
  end

  genvar gb;
  generate
    for (gb = 0; gb < PRF_BANK_COUNT; gb++) begin : g_bank
      rr_pick_one #(
        .WIDTH     (REQUESTER_COUNT),
        .LOG_WIDTH (LOG_REQUESTER_COUNT)
      ) u_pick (
        .req_i (bank_req[gb]),
        .ptr_i (rr_ptr_q[gb]),
        .gnt_o (bank_gnt[gb]),
        .idx_o (bank_idx[gb]),
        .any_o (bank_any[gb])
      );
    end
  endgenerate

  // Collect winners, advance pointers past each winner, form the next bank reads
  always_comb begin
    cand_granted = '0;
    rr_ptr_d     = rr_ptr_q;
    rd_valid_d   = '0;
    rd_upper_d   = '0;
    rd_rq_d      = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      cand_granted = cand_granted | bank_gnt[b];
      if (bank_any[b]) begin
        rr_ptr_d[b]   = (bank_idx[b] == LOG_REQUESTER_COUNT'(REQUESTER_COUNT - 1))
                        ? '0 : bank_idx[b] + LOG_REQUESTER_COUNT'(1);
        rd_valid_d[b] = 1'b1;
        rd_upper_d[b] = pr_upper(cand[bank_idx[b]].PR);
        rd_rq_d[b]    = bank_idx[b];
      end
    end
  end

  // Losers are parked in (or stay in) their buffer; winners free it; flush empties all
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_pr_d    = buf_pr_q;
    if (flush) begin
      buf_valid_d = '0;
    end else begin
      for (int r = 0; r < REQUESTER_COUNT; r++) begin
        if (cand_granted[r]) begin
          buf_valid_d[r] = 1'b0;
        end else if (cand[r].valid) begin
          buf_valid_d[r] = 1'b1;
          buf_pr_d[r]    = cand[r].PR;
        end
      end
    end
  end

  // State registers; reset discards buffered and in-flight requests
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the buffer PR payload is reset too; it is tiny and keeps outputs deterministic after reset.
      buf_valid_q <= '0;
      buf_pr_q    <= '0;
      rr_ptr_q    <= '0;
      rd_valid_q  <= '0;
      rd_upper_q  <= '0;
      rd_rq_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      buf_valid_q <= buf_valid_d;
      buf_pr_q    <= buf_pr_d;
      rr_ptr_q    <= rr_ptr_d;
      rd_valid_q  <= rd_valid_d;
      rd_upper_q  <= rd_upper_d;
      rd_rq_q     <= rd_rq_d;
    end
  end

endmodule
